// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with registered read port, occupancy flags and error pulses.
// Optional LIFO_STACK_WATERMARK_EN adds LIFO_High_Water (max occupancy since reset).
module lifo_stack_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int ALMOST_FULL  = 6,
  parameter int ALMOST_EMPTY = 2,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Push_In,
  input  logic                  Pop_In,
  input  logic                  Peek_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Data_Valid,
  output logic [CW-1:0]         LIFO_Count,
  output logic                  LIFO_Empty,
  output logic                  LIFO_Full,
  output logic                  LIFO_Almost_Empty,
  output logic                  LIFO_Almost_Full,
  output logic                  Overflow_Err,
  output logic                  Underflow_Err
`ifdef LIFO_STACK_WATERMARK_EN
  ,
  output logic [CW-1:0]         LIFO_High_Water
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPL,
    OP_PEEK,
    OP_OVF,
    OP_UNF
  } op_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic [CW-1:0]         top_full;
  logic [AW-1:0]         top_idx;
  logic                  has_data;
  logic                  is_full;
  logic                  rd;
  op_t                   op;

  assign has_data = (count != '0);
  assign is_full  = (count == CW'(DEPTH));
  assign top_full = count - CW'(1);
  assign top_idx  = top_full[AW-1:0];

  // Pop beats Peek, Peek beats Push; a push into an empty stack wins over a pop/peek.
  always_comb begin
    op = OP_NONE;
    if ((Pop_In || Peek_In) && !has_data && !Push_In)
      op = OP_UNF;
    else if (Pop_In && has_data)
      op = Push_In ? OP_REPL : OP_POP;
    else if (Peek_In && has_data)
      op = OP_PEEK;
    else if (Push_In)
      op = is_full ? OP_OVF : OP_PUSH;
  end

  assign rd = (op == OP_POP) || (op == OP_REPL) || (op == OP_PEEK);

  always_comb begin
    count_nxt = count;
    case (op)
      OP_PUSH: count_nxt = count + CW'(1);
      OP_POP:  count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      count         <= '0;
      Data_Out      <= '0;
      Data_Valid    <= 1'b0;
      Overflow_Err  <= 1'b0;
      Underflow_Err <= 1'b0;
    end else begin
      count         <= count_nxt;
      Data_Valid    <= rd;
      Overflow_Err  <= (op == OP_OVF);
      Underflow_Err <= (op == OP_UNF);
      if (rd)
        Data_Out <= mem[top_idx];
    end
  end

  // Storage is never cleared; writes are suppressed while reset is held.
  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      if (op == OP_PUSH)
        mem[count[AW-1:0]] <= Data_In;
      else if (op == OP_REPL)
        mem[top_idx] <= Data_In;
    end
  end

`ifdef LIFO_STACK_WATERMARK_EN
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In)
      LIFO_High_Water <= '0;
    else if (count_nxt > LIFO_High_Water)
      LIFO_High_Water <= count_nxt;
  end
`endif

  assign LIFO_Count        = count;
  assign LIFO_Empty        = (count == '0);
  assign LIFO_Full         = is_full;
  assign LIFO_Almost_Empty = (count <= CW'(ALMOST_EMPTY));
  assign LIFO_Almost_Full  = (count >= CW'(ALMOST_FULL));

endmodule
